// File: rtl/cell_pair_read_controller.sv
// cell_pair_read_controller: walks every reference particle of the home cell against the home cell and its half-shell neighbours, issuing each pair once; `define PAIR_COUNT_EN adds a saturating pair_count output
module cell_pair_read_controller #(
  parameter int PARTICLE_ID_WIDTH  = 7,
  parameter int NUM_NEIGHBOR_CELLS = 13,
  parameter int CELL_SEL_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         iter_start,
  input  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_num,
  input  logic [PARTICLE_ID_WIDTH-1:0] nb_particle_num,
  input  logic                         back_pressure,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_addr,
  output logic                         ref_rd_en,
  output logic [CELL_SEL_WIDTH-1:0]    nb_cell_sel,
  output logic [PARTICLE_ID_WIDTH-1:0] nb_addr,
  output logic                         nb_rd_en,
  output logic                         ref_switch,
  output logic                         busy,
  output logic                         reading_done
`ifdef PAIR_COUNT_EN
  ,output logic [15:0]                 pair_count
`endif
);
  localparam int AW = PARTICLE_ID_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, LOAD_REF, SCAN, DONE} state_t;
  state_t state;
  logic [AW-1:0] ref_q, nb_q, ref_num_q, nb_num;
  logic [CELL_SEL_WIDTH-1:0] cell_q;
  logic cell_adv, last_cell, last_ref;
  assign nb_num      = {1'b0, nb_particle_num};
  assign ref_addr    = ref_q[PARTICLE_ID_WIDTH-1:0];
  assign nb_addr     = nb_q[PARTICLE_ID_WIDTH-1:0];
  assign nb_cell_sel = cell_q;
  // a cell is finished when it is empty/exhausted or the read issued now is its last one
  always_comb begin
    cell_adv   = ~back_pressure & ((nb_q + AW'(1)) >= nb_num);
    last_cell  = cell_q == CELL_SEL_WIDTH'(NUM_NEIGHBOR_CELLS - 1);
    last_ref   = (ref_q + AW'(1)) == ref_num_q;
    nb_rd_en   = (state == SCAN) & ~back_pressure & (nb_q < nb_num);
    ref_switch = (state == SCAN) & last_cell & cell_adv;
  end
  // control FSM with registered strobes; home cell restarts one past the reference index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ref_q        <= '0;
      nb_q         <= '0;
      cell_q       <= '0;
      ref_num_q    <= '0;
      ref_rd_en    <= 1'b0;
      busy         <= 1'b0;
      reading_done <= 1'b0;
    end else begin
      ref_rd_en    <= 1'b0;
      reading_done <= 1'b0;
      case (state)
        IDLE: if (iter_start) begin
          ref_num_q <= {1'b0, ref_particle_num};
          ref_q     <= '0;
          nb_q      <= AW'(1);
          cell_q    <= '0;
          busy      <= 1'b1;
          if (ref_particle_num != '0) begin
            state     <= LOAD_REF;
            ref_rd_en <= 1'b1;
          end else begin
            state        <= DONE;
            reading_done <= 1'b1;
          end
        end
        LOAD_REF: state <= SCAN;
        SCAN: if (cell_adv) begin
          if (!last_cell) begin
            cell_q <= cell_q + 1'b1;
            nb_q   <= '0;
          end else if (last_ref) begin
            state        <= DONE;
            reading_done <= 1'b1;
          end else begin
            state     <= LOAD_REF;
            ref_rd_en <= 1'b1;
            ref_q     <= ref_q + AW'(1);
            nb_q      <= ref_q + AW'(2);
            cell_q    <= '0;
          end
        end else if (nb_rd_en) nb_q <= nb_q + AW'(1);
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PAIR_COUNT_EN
  // issued-pair counter, cleared per iteration, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pair_count <= '0;
    else if (state == IDLE && iter_start) pair_count <= '0;
    else if (nb_rd_en && pair_count != 16'hFFFF) pair_count <= pair_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_cell_pair_read_controller.sv
// tb_cell_pair_read_controller: table-driven iterations with a pair scoreboard, stall and mid-run reset sequences
module tb_cell_pair_read_controller;
  logic clk, rst, iter_start, back_pressure;
  logic [6:0] ref_particle_num, nb_particle_num, ref_addr, nb_addr;
  logic [3:0] nb_cell_sel;
  logic ref_rd_en, nb_rd_en, ref_switch, busy, reading_done;
`ifdef PAIR_COUNT_EN
  logic [15:0] pair_count;
`endif
  logic [6:0] cnt [16];
  int npass = 0, ntot = 0;

  cell_pair_read_controller dut (
    .clk(clk), .rst(rst), .iter_start(iter_start),
    .ref_particle_num(ref_particle_num), .nb_particle_num(nb_particle_num),
    .back_pressure(back_pressure), .ref_addr(ref_addr), .ref_rd_en(ref_rd_en),
    .nb_cell_sel(nb_cell_sel), .nb_addr(nb_addr), .nb_rd_en(nb_rd_en),
    .ref_switch(ref_switch), .busy(busy), .reading_done(reading_done)
`ifdef PAIR_COUNT_EN
    ,.pair_count(pair_count)
`endif
  );

  assign nb_particle_num = cnt[nb_cell_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ref_num; int c0; int pat; int bs; int bl; int poke; int rst_at;
    int e_ref; int e_nb; int e_sw; int e_lat;
  } vec_t;
  vec_t tbl [7];
  logic [17:0] sb [$];

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run(input int i);
    vec_t v;
    int n, lat, nr, ns, nbusy;
    logic [6:0] pa;
    logic [3:0] pc;
    logic pbp;
    logic [17:0] e;
    bit ab;
    v = tbl[i];
    for (int k = 0; k < 16; k++)
      cnt[k] = k == 0 ? 7'(v.c0) : k > 12 ? 7'd0 : v.pat == 0 ? 7'd1 : v.pat == 1 ? 7'd0 : 7'(k % 3);
    sb.delete();
    for (int r = 0; r < v.ref_num; r++)
      for (int c = 0; c < 13; c++)
        for (int a = (c == 0 ? r + 1 : 0); a < int'(cnt[c]); a++)
          sb.push_back({7'(r), 4'(c), 7'(a)});
    @(posedge clk); #1;
    iter_start = 1'b1; ref_particle_num = 7'(v.ref_num); back_pressure = 1'b0;
    @(posedge clk); #1;
    iter_start = 1'b0; ref_particle_num = 7'h55;
    n = 1; lat = 0; nr = 0; ns = 0; nbusy = 0; pbp = 1'b0; pa = '0; pc = '0; ab = 1'b0;
    while (n <= 200 && lat == 0) begin
      back_pressure = v.bl > 0 && n >= v.bs && n < v.bs + v.bl;
      iter_start = n == v.poke;
      #1;
      if (ref_rd_en) nr++;
      if (ref_switch) ns++;
      if (busy) nbusy++;
      if (nb_rd_en) begin
        if (sb.size() == 0) chk("extra_nb_rd", 1, 0);
        else begin
          e = sb.pop_front();
          chk("pair", int'({ref_addr, nb_cell_sel, nb_addr}), int'(e));
        end
      end
      if (back_pressure) chk("stall_rd", int'(nb_rd_en), 0);
      if (pbp) begin
        chk("stall_addr", int'(nb_addr), int'(pa));
        chk("stall_cell", int'(nb_cell_sel), int'(pc));
      end
      pbp = back_pressure; pa = nb_addr; pc = nb_cell_sel;
`ifdef PAIR_COUNT_EN
      if (n == 1) chk("pair_count_clr", int'(pair_count), 0);
`endif
      if (reading_done) lat = n;
      if (n == v.rst_at) begin
        chk("rst_mid_ref", int'(ref_addr), 1);
        rst = 1'b1; #1;
        chk("rst_async", int'({ref_addr, nb_addr, nb_cell_sel, ref_rd_en, nb_rd_en, ref_switch, busy, reading_done}), 0);
        ab = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    iter_start = 1'b0; back_pressure = 1'b0;
    if (ab) begin
      sb.delete();
      @(negedge clk) rst = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        chk("post_rst_idle", int'({busy, ref_rd_en, nb_rd_en}), 0);
      end
    end else begin
      chk("done_latency", lat, v.e_lat);
      chk("ref_rd_count", nr, v.e_ref);
      chk("ref_switch_count", ns, v.e_sw);
      chk("busy_cycles", nbusy, v.e_lat);
      chk("pairs_left", sb.size(), 0);
`ifdef PAIR_COUNT_EN
      chk("pair_count", int'(pair_count), v.e_nb);
`endif
      @(posedge clk); #1;
      chk("back_idle", int'({busy, reading_done}), 0);
    end
  endtask

  initial begin
    tbl[0] = '{2, 2, 0, 0, 0, 10, 0, 2, 25, 2, 29};
    tbl[1] = '{2, 2, 0, 5, 5, 0, 0, 2, 25, 2, 34};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[3] = '{3, 0, 1, 0, 0, 0, 0, 3, 0, 3, 43};
    tbl[4] = '{3, 3, 2, 0, 0, 0, 0, 3, 39, 3, 56};
    tbl[5] = '{2, 2, 0, 0, 0, 0, 20, 0, 0, 0, 0};
    tbl[6] = '{2, 2, 0, 0, 0, 0, 0, 2, 25, 2, 29};
    for (int k = 0; k < 16; k++) cnt[k] = '0;
    rst = 1'b1; iter_start = 1'b0; back_pressure = 1'b0; ref_particle_num = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'({ref_addr, nb_addr, nb_cell_sel, ref_rd_en, nb_rd_en, ref_switch, busy, reading_done}), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 7; i++) run(i);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
